mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the CPU fetch port and the CPU load/store port. It accepts one transaction at a time over a valid/ready handshake and drives the memory with a fixed read latency. It returns a one-cycle response pulse to the requester it served. Data accesses have priority; a starvation counter guarantees forward progress for fetch. It sits between cpu_top's fetch/memory stages and a shared synchronous RAM, replacing the split inst_mem/data_mem pair.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width; must be 32 (byte enables are 4 bits)
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..7
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_req_valid  in  1  fetch request
i_req_addr  in  ADDR_W  fetch byte address
i_req_ready  out  1  fetch request accepted this cycle
i_rsp_valid  out  1  one-cycle fetch response strobe
i_rsp_data  out  DATA_W  fetched instruction word
d_req_valid  in  1  data request
d_req_we  in  1  1 = write, 0 = read
d_req_be  in  4  byte enables (write only)
d_req_addr  in  ADDR_W  data byte address
d_req_wdata  in  DATA_W  write data, already lane-aligned
d_req_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  one-cycle data response strobe (reads and writes)
d_rsp_data  out  DATA_W  read word (0 for writes)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, immediate): state=IDLE; every *_ready, *_rsp_valid, mem_en, mem_we = 0; mem_be=0; mem_addr, mem_wdata, rsp_data = 0; starve_cnt=0; lat_cnt=0.
- States:
  - IDLE: arbitration allowed.
  - WAIT: lat_cnt counts MEM_LAT cycles.
  - RESP: the response cycle; arbitration is also allowed here.
- Arbitration (IDLE or RESP):
  - Grant data if d_req_valid, unless starve_cnt==STARVE_MAX and i_req_valid; otherwise grant fetch if i_req_valid.
  - The ready of the granted requester is combinational, high in the same cycle. The non-granted ready is 0.
- On a grant (cycle T):
  - mem_en=1 for exactly cycle T; mem_we/be/addr/wdata are driven combinationally from the granted request.
  - Fetch: we=0, be=4'b1111, wdata=0.
  - Next state is WAIT; lat_cnt loads MEM_LAT-1.
- WAIT: at lat_cnt==0 (cycle T+MEM_LAT), capture mem_rdata into the owner's rsp_data and go to RESP. Otherwise decrement lat_cnt.
- RESP (cycle T+MEM_LAT+1):
  - The owner's rsp_valid=1 for exactly one cycle.
  - For writes, d_rsp_data=0.
  - Next state is WAIT on a new grant this cycle, else IDLE.
  - Peak throughput: one transaction per MEM_LAT+1 cycles.
- Responses have no back-pressure; the requester must take them.
- A requester must hold valid and payload stable until ready. Dropping valid before ready is legal and simply cancels the request.
- While in WAIT, both readies are 0 regardless of valid.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each data grant while i_req_valid=1.
  - Cleared on any fetch grant.
  - Cleared when i_req_valid=0 in an arbitration cycle.
- Simultaneous valids with starve_cnt<STARVE_MAX: data wins.
- Address bits [1:0] are ignored (forced to 0 on mem_addr). Misalignment checking is the requester's job.
- Reset mid-transaction: the outstanding access is abandoned; no rsp_valid is ever emitted for it. The first legal grant is in the first cycle after rst deasserts.
- rsp_data holds its last captured value until the next capture.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} arb_state_t
  - typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t
  - localparam BE_FULL = 4'b1111
- Sub-module arb_starve_ctr (the saturating starvation counter plus its force_fetch output). The FSM and latency counter stay in mem_arbiter.

Test Plan:
- Reset, then fetch only, addr 0x10, MEM_LAT=1, mem_rdata=0x00500093 -> i_req_ready at T, mem_en at T with mem_addr=0x10, i_rsp_valid at T+2 with data 0x00500093, no d_rsp_valid.
- Both valid continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; each grant is MEM_LAT+1 cycles apart.
- Data write addr 0x23, be=4'b0100, wdata=0x00AB0000 -> mem_addr=0x20, mem_we=1, mem_be=4'b0100; d_rsp_valid at T+2 with d_rsp_data=0.
- MEM_LAT=3, back-to-back data reads -> second d_req_ready coincides with the first d_rsp_valid at T+4; the second mem_en is also at T+4.
- Assert rst during WAIT after a fetch grant -> all outputs 0 immediately; no i_rsp_valid afterwards; a new fetch is accepted in the first cycle after release.
- Data valid during WAIT -> d_req_ready stays 0 until the RESP cycle, then is granted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;

    localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-side signal bundle for mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;

    logic              d_req_valid;
    logic              d_req_we;
    logic [3:0]        d_req_be;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants taken while a fetch waits; raises force_fetch at the limit.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_cycle,
    input  logic i_req_valid,
    input  logic grant_d,
    input  logic grant_i,
    output logic force_fetch
);
    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_i || (arb_cycle && !i_req_valid)) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_fetch = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-ported memory with fixed read latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    arb_state_t        state, state_nxt;
    arb_owner_t        owner;
    logic              owner_we;
    logic [2:0]        lat_cnt;
    logic              arb_cycle, force_fetch, grant_d, grant_i, grant_any;
    logic [DATA_W-1:0] i_rsp_data_q, d_rsp_data_q;

    logic              i_ready_c, d_ready_c, i_rsp_v_c, d_rsp_v_c;
    logic              mem_en_c, mem_we_c;
    logic [3:0]        mem_be_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Gated by rst so no ready or mem_en can leak out while reset is held.
    assign arb_cycle = !rst && ((state == ST_IDLE) || (state == ST_RESP));
    assign grant_d   = arb_cycle && bus.d_req_valid && !(force_fetch && bus.i_req_valid);
    assign grant_i   = arb_cycle && bus.i_req_valid && !grant_d;
    assign grant_any = grant_d || grant_i;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk         (clk),
        .rst         (rst),
        .arb_cycle   (arb_cycle),
        .i_req_valid (bus.i_req_valid),
        .grant_d     (grant_d),
        .grant_i     (grant_i),
        .force_fetch (force_fetch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_any) state_nxt = ST_WAIT;
            ST_WAIT: if (lat_cnt == 3'd0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = grant_any ? ST_WAIT : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        i_ready_c   = grant_i;
        d_ready_c   = grant_d;
        i_rsp_v_c   = (state == ST_RESP) && (owner == OWN_FETCH);
        d_rsp_v_c   = (state == ST_RESP) && (owner == OWN_DATA);
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_be_c    = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (grant_d) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.d_req_we;
            mem_be_c    = bus.d_req_be;
            mem_addr_c  = {bus.d_req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_c = bus.d_req_wdata;
        end else if (grant_i) begin
            mem_en_c    = 1'b1;
            mem_be_c    = BE_FULL;
            mem_addr_c  = {bus.i_req_addr[ADDR_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= OWN_FETCH;
            owner_we     <= 1'b0;
            lat_cnt      <= '0;
            i_rsp_data_q <= '0;
            d_rsp_data_q <= '0;
        end else if (grant_any) begin
            owner    <= grant_d ? OWN_DATA : OWN_FETCH;
            owner_we <= grant_d && bus.d_req_we;
            lat_cnt  <= LAT_INIT;
        end else if (state == ST_WAIT) begin
            if (lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end else if (owner == OWN_FETCH) begin
                i_rsp_data_q <= bus.mem_rdata;
            end else begin
                d_rsp_data_q <= owner_we ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.i_req_ready = i_ready_c;
    assign bus.d_req_ready = d_ready_c;
    assign bus.i_rsp_valid = i_rsp_v_c;
    assign bus.d_rsp_valid = d_rsp_v_c;
    assign bus.i_rsp_data  = i_rsp_data_q;
    assign bus.d_rsp_data  = d_rsp_data_q;
    assign bus.mem_en      = mem_en_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_be      = mem_be_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table at MEM_LAT=1 plus multi-cycle corner sequences.
module tb_mem_arbiter;

    typedef struct packed {
        logic        i_v;
        logic [31:0] i_addr;
        logic        d_v;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
    } in_t;

    typedef struct packed {
        logic        i_rdy;
        logic        i_rsp_v;
        logic [31:0] i_rsp_data;
        logic        d_rdy;
        logic        d_rsp_v;
        logic [31:0] d_rsp_data;
        logic        mem_en;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst), .bus(b3));

    // Memory models: 64 words, read data appears MEM_LAT cycles after mem_en.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] rd1;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        rd1 <= b1.mem_en ? mem1[b1.mem_addr[7:2]] : 32'hDEADBEEF;
        if (b1.mem_en && b1.mem_we)
            for (int b = 0; b < 4; b++)
                if (b1.mem_be[b]) mem1[b1.mem_addr[7:2]][8*b +: 8] <= b1.mem_wdata[8*b +: 8];
    end
    assign b1.mem_rdata = rd1;

    always @(posedge clk) begin
        p3[0] <= b3.mem_en ? mem3[b3.mem_addr[7:2]] : 32'hDEADBEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b3.mem_rdata = p3[2];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive1(input in_t v);
        b1.i_req_valid = v.i_v;
        b1.i_req_addr  = v.i_addr;
        b1.d_req_valid = v.d_v;
        b1.d_req_we    = v.d_we;
        b1.d_req_be    = v.d_be;
        b1.d_req_addr  = v.d_addr;
        b1.d_req_wdata = v.d_wdata;
    endtask

    function automatic out_t sample1();
        return '{b1.i_req_ready, b1.i_rsp_valid, b1.i_rsp_data,
                 b1.d_req_ready, b1.d_rsp_valid, b1.d_rsp_data,
                 b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr, b1.mem_wdata};
    endfunction

    function automatic out_t sample3();
        return '{b3.i_req_ready, b3.i_rsp_valid, b3.i_rsp_data,
                 b3.d_req_ready, b3.d_rsp_valid, b3.d_rsp_data,
                 b3.mem_en, b3.mem_we, b3.mem_be, b3.mem_addr, b3.mem_wdata};
    endfunction

    vec_t  vecs [12];
    in_t   idle_in;
    out_t  zero_out;
    byte   gnt_kind [10];
    int    gnt_cyc  [10];
    int    ng;
    int    t2;
    string exp_order;

    initial begin
        idle_in  = '0;
        zero_out = '0;
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[4]  = 32'h00500093;
        mem1[8]  = 32'h11111111;
        mem1[16] = 32'hCAFE0001;
        mem1[17] = 32'h0D0D0D0D;
        mem3[4]  = 32'h00500093;
        mem3[8]  = 32'h11111111;
        drive1(idle_in);
        b3.i_req_valid = 1'b0; b3.i_req_addr = '0;
        b3.d_req_valid = 1'b0; b3.d_req_we = 1'b0; b3.d_req_be = '0;
        b3.d_req_addr  = '0;   b3.d_req_wdata = '0;

        // in: i_v,i_addr,d_v,d_we,d_be,d_addr,d_wdata
        // exp: i_rdy,i_rsp_v,i_rsp_data,d_rdy,d_rsp_v,d_rsp_data,mem_en,mem_we,mem_be,mem_addr,mem_wdata
        vecs[0]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[1]  = '{'{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0}};
        vecs[2]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[3]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[4]  = '{'{1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h23, 32'h00AB0000},
                     '{1'b0, 1'b0, 32'h00500093, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h20, 32'h00AB0000}};
        vecs[5]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[6]  = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[7]  = '{'{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0}};
        vecs[8]  = '{'{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[9]  = '{'{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b1, 1'b1, 32'h11AB1111, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0}};
        vecs[10] = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h11AB1111, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};
        vecs[11] = '{'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 32'h00500093, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_dut1", 160'(sample1()), 160'(zero_out));
        chk("reset_dut3", 160'(sample3()), 160'(zero_out));
        @(negedge clk);
        rst = 1'b0;

        // Vector table, MEM_LAT=1
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            drive1(vecs[v].in);
            #1;
            chk($sformatf("vec%0d", v), 160'(sample1()), 160'(vecs[v].exp));
        end

        // Starvation: both requesters valid continuously
        exp_order = "DDDDIDDDDI";
        ng = 0;
        @(negedge clk);
        drive1('{1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0});
        for (int c = 0; c < 40 && ng < 10; c++) begin
            #1;
            if (b1.d_req_ready && b1.i_req_ready) chk("starve_both_ready", 160'(1), 160'(0));
            if (b1.d_req_ready) begin
                gnt_kind[ng] = "D"; gnt_cyc[ng] = c; ng++;
            end else if (b1.i_req_ready) begin
                gnt_kind[ng] = "I"; gnt_cyc[ng] = c; ng++;
            end
            @(negedge clk);
        end
        drive1(idle_in);
        chk("starve_grant_count", 160'(ng), 160'(10));
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("starve_order%0d", i), 160'(gnt_kind[i]), 160'(exp_order[i]));
            if (i > 0) chk($sformatf("starve_gap%0d", i), 160'(gnt_cyc[i] - gnt_cyc[i-1]), 160'(2));
        end
        repeat (2) @(negedge clk);

        // MEM_LAT=3 back-to-back data reads
        b3.d_req_valid = 1'b1; b3.d_req_addr = 32'h10;
        #1;
        chk("lat3_grant1_ready", 160'(b3.d_req_ready), 160'(1));
        chk("lat3_grant1_addr", 160'(b3.mem_addr), 160'(32'h10));
        @(negedge clk);
        b3.d_req_addr = 32'h20;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk($sformatf("lat3_wait%0d", k),
                160'({b3.d_req_ready, b3.mem_en, b3.d_rsp_valid}), 160'(3'b000));
            @(negedge clk);
        end
        #1;
        chk("lat3_resp1_valid", 160'(b3.d_rsp_valid), 160'(1));
        chk("lat3_resp1_data", 160'(b3.d_rsp_data), 160'(32'h00500093));
        chk("lat3_grant2", 160'({b3.d_req_ready, b3.mem_en}), 160'(2'b11));
        chk("lat3_grant2_addr", 160'(b3.mem_addr), 160'(32'h20));
        t2 = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            b3.d_req_valid = 1'b0;
            #1;
            if (b3.d_rsp_valid) begin
                t2 = c;
                break;
            end
        end
        chk("lat3_resp2_cycle", 160'(t2), 160'(4));
        chk("lat3_resp2_data", 160'(b3.d_rsp_data), 160'(32'h11111111));

        // Reset asserted during WAIT of a fetch
        @(negedge clk);
        drive1('{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        #1;
        chk("rstwait_grant", 160'(b1.i_req_ready), 160'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwait_zero_dut1", 160'(sample1()), 160'(zero_out));
        chk("rstwait_zero_dut3", 160'(sample3()), 160'(zero_out));
        @(negedge clk);
        #1;
        chk("rstwait_hold_zero", 160'(sample1()), 160'(zero_out));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstrel_grant", 160'({b1.i_req_ready, b1.mem_en, b1.i_rsp_valid}), 160'(3'b110));
        chk("rstrel_addr", 160'(b1.mem_addr), 160'(32'h10));
        @(negedge clk);
        drive1(idle_in);
        #1;
        chk("rstrel_no_rsp", 160'(b1.i_rsp_valid), 160'(0));
        @(negedge clk);
        #1;
        chk("rstrel_rsp", 160'({b1.i_rsp_valid, b1.i_rsp_data}), 160'({1'b1, 32'h00500093}));
        @(negedge clk);
        #1;
        chk("rstrel_rsp_pulse", 160'(b1.i_rsp_valid), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
